matmul_arbiter: RTL and testbench

Control-plane arbiter that shares a single matrix-multiply engine between up to `NUM_REQ` requesters (DMA, scheduler, host path). It picks one requester at a time by round-robin and checks its M/N/K dimensions. It then sequences the engine's input/output valid-ready handshakes and routes the completion back to the winner. The operand mux and the result demux are external and are steered by `sel_id`.

---
 rtl/matmul_arbiter.sv | 241 ++++++++++++++++++++++++
 tb/tb_matmul_arbiter.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/matmul_arbiter.sv
// -----------------------------------------------------------------------------
// matmul_arbiter
//
// Shares one matrix-multiply engine between NUM_REQ requesters. A round-robin
// pointer picks the next requester, its M/N/K dimensions are registered and
// range-checked, and the FSM then sequences the engine's job (valid/ready in)
// and result (valid/ready out) handshakes. The completion is routed back to
// the winner. Operand and result muxes live outside this block and are
// steered by o_sel_id.
//
// Optional feature macro: MATMUL_ARB_WATCHDOG_EN
//   defined   : WAIT-state watchdog, sticky o_timeout_err, cleared by i_err_clr
//   undefined : no counter, o_timeout_err tied low, i_err_clr ignored
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   i_req_valid         per-requester job request
//   o_req_ready         one-cycle accept pulse to the granted requester
//   i_req_dims          per requester {m[11:8], n[7:4], k[3:0]}
//   o_sel_id            current owner (operand / result mux select)
//   o_eng_valid_in      job valid to the engine
//   i_eng_ready_in      engine can accept a job
//   o_eng_m/n/k_dim     registered dims of the job being run
//   i_eng_valid_out     engine result valid
//   o_eng_ready_out     result accepted (follows the owner's rsp_ready)
//   o_rsp_valid         one-hot completion to the owner
//   o_rsp_err           completion is a dimension rejection
//   i_rsp_ready         per-requester completion accept
//   o_busy              FSM is not idle
//   o_jobs_done         completed engine jobs, wraps at 16 bits
//   o_timeout_err       sticky watchdog flag
//   i_err_clr           clears o_timeout_err
// -----------------------------------------------------------------------------
module matmul_arbiter #(
   parameter int NUM_REQ        = 4,
   parameter int ID_W           = 2,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NUM_REQ-1:0]    i_req_valid,
   output logic [NUM_REQ-1:0]    o_req_ready,
   input  logic [NUM_REQ*12-1:0] i_req_dims,
   output logic [ID_W-1:0]       o_sel_id,
   output logic                  o_eng_valid_in,
   input  logic                  i_eng_ready_in,
   output logic [3:0]            o_eng_m_dim,
   output logic [3:0]            o_eng_n_dim,
   output logic [3:0]            o_eng_k_dim,
   input  logic                  i_eng_valid_out,
   output logic                  o_eng_ready_out,
   output logic [NUM_REQ-1:0]    o_rsp_valid,
   output logic                  o_rsp_err,
   input  logic [NUM_REQ-1:0]    i_rsp_ready,
   output logic                  o_busy,
   output logic [15:0]           o_jobs_done,
   output logic                  o_timeout_err,
   input  logic                  i_err_clr
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RETURN,
      S_REJECT
   } state_t;

   state_t               r_state;
   state_t               w_next_state;

   logic [ID_W-1:0]      r_sel_id;
   logic [ID_W-1:0]      r_rr_ptr;
   logic [11:0]          r_dims;
   logic [15:0]          r_jobs_done;
   logic                 r_rej_first;   // first cycle of REJECT

   logic                 w_grant_any;
   logic [ID_W-1:0]      w_grant_id;
   logic [ID_W-1:0]      w_idx;
   logic [11:0]          w_grant_dims;
   logic                 w_dims_bad;
   logic [NUM_REQ-1:0]   w_sel_onehot;
   logic                 w_rsp_ack;

   function automatic logic dim_bad(input logic [3:0] d);
      return (d == 4'd0) || (d > 4'd8);
   endfunction

   // Round-robin search: scan offsets from high to low so the smallest offset
   // from r_rr_ptr is the last (winning) assignment. ID_W bits wrap naturally
   // because NUM_REQ is a power of two.
   always_comb begin
      // NOTE: every variable gets a default before any branch so no latch is inferred.
      w_grant_any = 1'b0;
      w_grant_id  = '0;
      w_idx       = '0;
      for (int off = NUM_REQ - 1; off >= 0; off--) begin
         w_idx = r_rr_ptr + ID_W'(off);
         if (i_req_valid[w_idx]) begin
            w_grant_any = 1'b1;
            w_grant_id  = w_idx;
         end
      end
   end

   assign w_grant_dims = i_req_dims[int'(w_grant_id)*12 +: 12];
   assign w_dims_bad   = dim_bad(w_grant_dims[11:8]) ||
                         dim_bad(w_grant_dims[7:4])  ||
                         dim_bad(w_grant_dims[3:0]);

   assign w_sel_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << r_sel_id;
   assign w_rsp_ack    = i_rsp_ready[r_sel_id];

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
         r_state <= w_next_state;
      end
   end

   // --------------------------------------------------------------- next state
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         S_IDLE:   if (w_grant_any)     w_next_state = w_dims_bad ? S_REJECT : S_ISSUE;
         S_ISSUE:  if (i_eng_ready_in)  w_next_state = S_WAIT;
         S_WAIT:   if (i_eng_valid_out) w_next_state = S_RETURN;
         S_RETURN: if (w_rsp_ack)       w_next_state = S_IDLE;
         S_REJECT: if (w_rsp_ack)       w_next_state = S_IDLE;
         default:                       w_next_state = S_IDLE;
      endcase
   end

   // ------------------------------------------------------------------ outputs
   // Everything is decoded from state; the only input terms are the ready
   // pass-throughs that must be combinational within the handshake cycle.
   always_comb begin
      o_eng_valid_in  = 1'b0;
      o_req_ready     = '0;
      o_eng_ready_out = 1'b0;
      o_rsp_valid     = '0;
      o_rsp_err       = 1'b0;
      o_busy          = (r_state != S_IDLE);
      o_eng_m_dim     = 4'd0;
      o_eng_n_dim     = 4'd0;
      o_eng_k_dim     = 4'd0;
      case (r_state)
         S_ISSUE: begin
            o_eng_valid_in = 1'b1;
            if (i_eng_ready_in) o_req_ready = w_sel_onehot;
            {o_eng_m_dim, o_eng_n_dim, o_eng_k_dim} = r_dims;
         end
         S_WAIT: begin
            {o_eng_m_dim, o_eng_n_dim, o_eng_k_dim} = r_dims;
         end
         S_RETURN: begin
            o_rsp_valid     = w_sel_onehot;
            o_eng_ready_out = w_rsp_ack;
            {o_eng_m_dim, o_eng_n_dim, o_eng_k_dim} = r_dims;
         end
         S_REJECT: begin
            // Rejected dims never reach the engine; the request is consumed
            // with a single accept pulse on entry.
            o_rsp_valid = w_sel_onehot;
            o_rsp_err   = 1'b1;
            if (r_rej_first) o_req_ready = w_sel_onehot;
         end
         default: ;
      endcase
   end

   // ----------------------------------------------------------------- datapath
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel_id    <= '0;
         r_rr_ptr    <= '0;
         r_dims      <= '0;
         r_jobs_done <= '0;
         r_rej_first <= 1'b0;
      end else begin
         r_rej_first <= 1'b0;
         // Dims are captured only at grant; a requester may drop its request
         // afterwards and the registered copy is still what gets issued.
         if (r_state == S_IDLE && w_grant_any) begin
            r_sel_id    <= w_grant_id;
            r_dims      <= w_grant_dims;
            r_rej_first <= w_dims_bad;
         end
         if ((r_state == S_RETURN || r_state == S_REJECT) && w_rsp_ack) begin
            r_rr_ptr <= r_sel_id + ID_W'(1);
         end
         if (r_state == S_RETURN && w_rsp_ack) begin
            r_jobs_done <= r_jobs_done + 16'd1;
         end
      end
   end

   assign o_sel_id    = r_sel_id;
   assign o_jobs_done = r_jobs_done;

   // ----------------------------------------------------------------- watchdog
`ifdef MATMUL_ARB_WATCHDOG_EN
   localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [WD_W-1:0] r_wd_cnt;
   logic            r_timeout_err;

   // The counter saturates at TIMEOUT_CYCLES so a very long wait cannot wrap
   // and re-fire. The flag is set on the edge where the count reaches the
   // limit, so it is visible in the following WAIT cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wd_cnt      <= '0;
         r_timeout_err <= 1'b0;
      end else begin
         if (r_state == S_ISSUE && w_next_state == S_WAIT) begin
            r_wd_cnt <= '0;
         end else if (r_state == S_WAIT && r_wd_cnt != WD_W'(TIMEOUT_CYCLES)) begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1);
         end
         // Set has priority over a simultaneous clear.
         if (r_state == S_WAIT && r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1)) begin
            r_timeout_err <= 1'b1;
         end else if (i_err_clr) begin
            r_timeout_err <= 1'b0;
         end
      end
   end

   assign o_timeout_err = r_timeout_err;
`else
   logic [31:0] w_unused_cfg;
   assign w_unused_cfg  = {TIMEOUT_CYCLES[30:0], i_err_clr};
   assign o_timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_matmul_arbiter.sv
module tb_matmul_arbiter;

   localparam int NUM_REQ = 4;
   localparam int ID_W    = 2;
   localparam int TMO     = 16;

   logic                  clk = 1'b0;
   logic                  rst;
   logic [NUM_REQ-1:0]    req_valid;
   logic [NUM_REQ-1:0]    req_ready;
   logic [NUM_REQ*12-1:0] req_dims;
   logic [ID_W-1:0]       sel_id;
   logic                  eng_valid_in;
   logic                  eng_ready_in;
   logic [3:0]            eng_m_dim, eng_n_dim, eng_k_dim;
   logic                  eng_valid_out;
   logic                  eng_ready_out;
   logic [NUM_REQ-1:0]    rsp_valid;
   logic                  rsp_err;
   logic [NUM_REQ-1:0]    rsp_ready;
   logic                  busy;
   logic [15:0]           jobs_done;
   logic                  timeout_err;
   logic                  err_clr;

   int checks   = 0;
   int failures = 0;
   int pulses;
   int holds;

   matmul_arbiter #(
      .NUM_REQ(NUM_REQ), .ID_W(ID_W), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_req_valid    (req_valid),
      .o_req_ready    (req_ready),
      .i_req_dims     (req_dims),
      .o_sel_id       (sel_id),
      .o_eng_valid_in (eng_valid_in),
      .i_eng_ready_in (eng_ready_in),
      .o_eng_m_dim    (eng_m_dim),
      .o_eng_n_dim    (eng_n_dim),
      .o_eng_k_dim    (eng_k_dim),
      .i_eng_valid_out(eng_valid_out),
      .o_eng_ready_out(eng_ready_out),
      .o_rsp_valid    (rsp_valid),
      .o_rsp_err      (rsp_err),
      .i_rsp_ready    (rsp_ready),
      .o_busy         (busy),
      .o_jobs_done    (jobs_done),
      .o_timeout_err  (timeout_err),
      .i_err_clr      (err_clr)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Returns 2 time units after a rising edge; inputs are driven there and
   // outputs are sampled one unit later, well away from either clock edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Full job with an immediately ready engine and requester; the caller has
   // already raised the requests and is sitting in an IDLE cycle.
   task automatic do_job(input int id);
      #1; check("job_idle_busy", 32'(busy), 0);
      tick();
      #1; check("job_sel", 32'(sel_id), id);
      check("job_req_ready", 32'(req_ready), 1 << id);
      check("job_evi", 32'(eng_valid_in), 1);
      tick();
      eng_valid_out = 1'b1;
      #1; check("job_wait_evi", 32'(eng_valid_in), 0);
      tick();
      eng_valid_out = 1'b0;
      #1; check("job_rsp_valid", 32'(rsp_valid), 1 << id);
      check("job_ero", 32'(eng_ready_out), 1);
      tick();
   endtask

   initial begin
      rst = 1'b1; req_valid = '0; req_dims = '0; eng_ready_in = 1'b0;
      eng_valid_out = 1'b0; rsp_ready = '0; err_clr = 1'b0;

      // ---------------- reset state
      tick(); tick();
      #1;
      check("rst_busy", 32'(busy), 0);
      check("rst_evi", 32'(eng_valid_in), 0);
      check("rst_rsp_valid", 32'(rsp_valid), 0);
      check("rst_req_ready", 32'(req_ready), 0);
      check("rst_jobs", 32'(jobs_done), 0);
      check("rst_sel", 32'(sel_id), 0);
      check("rst_tmo", 32'(timeout_err), 0);
      check("rst_dims", 32'({eng_m_dim, eng_n_dim, eng_k_dim}), 0);
      rst = 1'b0;
      tick();

      // ---------------- single job: requester 2, dims 8x8x8, 70-cycle engine
      req_valid = 4'b0100; req_dims[2*12 +: 12] = 12'h888;
      #1; check("sj_c0_evi", 32'(eng_valid_in), 0);
      tick();
      eng_ready_in = 1'b1;
      #1; check("sj_c1_evi", 32'(eng_valid_in), 1);
      check("sj_sel", 32'(sel_id), 2);
      check("sj_req_ready", 32'(req_ready), 32'h4);
      check("sj_dims", 32'({eng_m_dim, eng_n_dim, eng_k_dim}), 32'h888);
      tick();
      req_valid = '0; eng_ready_in = 1'b0;
      #1; check("sj_wait_evi", 32'(eng_valid_in), 0);
      check("sj_wait_busy", 32'(busy), 1);
      for (int c = 0; c < 69; c++) tick();
      eng_valid_out = 1'b1;
      #1; check("sj_pre_rsp", 32'(rsp_valid), 0);
      check("sj_wait_dims", 32'({eng_m_dim, eng_n_dim, eng_k_dim}), 32'h888);
      tick();
      eng_valid_out = 1'b0;
      #1; check("sj_rsp_valid", 32'(rsp_valid), 32'h4);
      check("sj_rsp_err", 32'(rsp_err), 0);
      check("sj_ero_low", 32'(eng_ready_out), 0);
      rsp_ready = 4'b0100;
      #1; check("sj_ero_high", 32'(eng_ready_out), 1);
      tick();
      rsp_ready = '0;
      #1; check("sj_idle", 32'(busy), 0);
      check("sj_jobs", 32'(jobs_done), 1);
      check("sj_rsp_clear", 32'(rsp_valid), 0);

      // ---------------- reset mid-WAIT (round-robin pointer is now 3)
      req_valid = 4'b1000; req_dims[3*12 +: 12] = 12'h111;
      tick();
      eng_ready_in = 1'b1;
      tick();
      req_valid = '0;
      #1; check("rw_busy", 32'(busy), 1);
      #2; rst = 1'b1;
      #1;
      check("rw_busy0", 32'(busy), 0);
      check("rw_jobs0", 32'(jobs_done), 0);
      check("rw_sel0", 32'(sel_id), 0);
      check("rw_tmo0", 32'(timeout_err), 0);
      check("rw_evi0", 32'(eng_valid_in), 0);
      check("rw_rsp0", 32'(rsp_valid), 0);
      rst = 1'b0;
      tick();

      // ---------------- round robin with all requesters asserted
      // Pointer back at 0 after reset, so the order starts at 0.
      for (int i = 0; i < NUM_REQ; i++) req_dims[i*12 +: 12] = 12'h111;
      req_valid = 4'b1111; rsp_ready = 4'b1111; eng_ready_in = 1'b1;
      do_job(0);
      do_job(1);
      do_job(2);
      do_job(3);
      do_job(0);
      req_valid = '0; rsp_ready = '0;
      #1; check("rr_jobs", 32'(jobs_done), 5);

      // ---------------- reject: requester 1 dims {0,4,9}; requester 2 waiting
      req_dims[1*12 +: 12] = 12'h049;
      req_dims[2*12 +: 12] = 12'h123;
      req_valid = 4'b0110;
      tick();
      #1; check("rj_rsp_valid", 32'(rsp_valid), 32'h2);
      check("rj_err", 32'(rsp_err), 1);
      check("rj_req_ready", 32'(req_ready), 32'h2);
      check("rj_evi", 32'(eng_valid_in), 0);
      check("rj_sel", 32'(sel_id), 1);
      tick();
      req_valid = 4'b0100;
      #1; check("rj_rr_once", 32'(req_ready), 0);
      check("rj_hold", 32'(rsp_valid), 32'h2);
      check("rj_evi2", 32'(eng_valid_in), 0);
      rsp_ready = 4'b0010;
      tick();
      rsp_ready = '0;
      #1; check("rj_jobs", 32'(jobs_done), 5);
      check("rj_err_clr", 32'(rsp_err), 0);
      check("rj_idle", 32'(busy), 0);
      tick();
      #1; check("rj_next_sel", 32'(sel_id), 2);
      check("rj_next_evi", 32'(eng_valid_in), 1);
      check("rj_next_m", 32'(eng_m_dim), 1);
      check("rj_next_ready", 32'(req_ready), 32'h4);
      tick();
      req_valid = '0; eng_valid_out = 1'b1;
      tick();
      eng_valid_out = 1'b0; rsp_ready = 4'b0100;
      #1; check("rj_next_rsp", 32'(rsp_valid), 32'h4);
      tick();
      rsp_ready = '0;
      #1; check("rj_next_jobs", 32'(jobs_done), 6);

      // ---------------- backpressure: engine not ready 5 cycles, rsp_ready low 3
      req_valid = 4'b1000; req_dims[3*12 +: 12] = 12'h234; eng_ready_in = 1'b0;
      pulses = 0; holds = 0;
      tick();
      for (int c = 0; c < 5; c++) begin
         #1;
         if (eng_valid_in) holds++;
         if (req_ready != '0) pulses++;
         tick();
      end
      eng_ready_in = 1'b1;
      #1;
      if (eng_valid_in) holds++;
      if (req_ready != '0) pulses++;
      check("bp_ready_at_hs", 32'(req_ready), 32'h8);
      check("bp_dims", 32'({eng_m_dim, eng_n_dim, eng_k_dim}), 32'h234);
      tick();
      req_valid = '0; eng_ready_in = 1'b0;
      #1;
      if (eng_valid_in) holds++;
      if (req_ready != '0) pulses++;
      check("bp_evi_cycles", 32'(holds), 6);
      check("bp_pulses", 32'(pulses), 1);
      eng_valid_out = 1'b1;
      tick();
      eng_valid_out = 1'b0;
      for (int c = 0; c < 3; c++) begin
         #1; check("bp_rsp_hold", 32'(rsp_valid), 32'h8);
         check("bp_ero_low", 32'(eng_ready_out), 0);
         tick();
      end
      rsp_ready = 4'b1000;
      #1; check("bp_ero_high", 32'(eng_ready_out), 1);
      tick();
      rsp_ready = '0;
      #1; check("bp_jobs", 32'(jobs_done), 7);
      check("bp_idle", 32'(busy), 0);

`ifdef MATMUL_ARB_WATCHDOG_EN
      // ---------------- watchdog: 20 silent WAIT cycles with a limit of 16
      req_valid = 4'b0001; req_dims[0 +: 12] = 12'h111; eng_ready_in = 1'b1;
      tick();
      tick();
      req_valid = '0; eng_ready_in = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         #1; check("wd_flag", 32'(timeout_err), (c >= 17) ? 1 : 0);
         tick();
      end
      eng_valid_out = 1'b1;
      tick();
      eng_valid_out = 1'b0; rsp_ready = 4'b0001;
      #1; check("wd_late_rsp", 32'(rsp_valid), 1);
      check("wd_still_set", 32'(timeout_err), 1);
      tick();
      rsp_ready = '0;
      #1; check("wd_jobs", 32'(jobs_done), 8);
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      #1; check("wd_cleared", 32'(timeout_err), 0);
`else
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      #1; check("wd_tied_low", 32'(timeout_err), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
